flash_bus_arbiter: RTL and testbench

FLASH_BUS_ARBITER -- requirements
Module: flash_bus_arbiter

---
 rtl/flash_bus_arbiter_if.sv | 45 ++++
 rtl/flash_bus_arbiter.sv | 110 +++++++++++
 tb/tb_flash_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/flash_bus_arbiter_if.sv
// Bus bundle between the two SPI flash masters, the arbiter and the flash pads.
// The slave modport is the arbiter's view; the master modport is the masters' and pads' view.
interface flash_bus_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0;
    logic             gnt0;
    logic             m0_csb;
    logic             m0_clk;
    logic [3:0]       m0_io_oe;
    logic [3:0]       m0_io_do;
    logic [3:0]       m0_io_di;
    logic             req1;
    logic             gnt1;
    logic             m1_csb;
    logic             m1_clk;
    logic [3:0]       m1_io_oe;
    logic [3:0]       m1_io_do;
    logic [3:0]       m1_io_di;
    logic             flash_csb;
    logic             flash_clk;
    logic [3:0]       flash_io_oe;
    logic [3:0]       flash_io_do;
    logic [3:0]       flash_io_di;
    logic             busy;
    logic [CNT_W-1:0] abort_cnt;

    modport slave (
        input  req0, m0_csb, m0_clk, m0_io_oe, m0_io_do,
        input  req1, m1_csb, m1_clk, m1_io_oe, m1_io_do,
        input  flash_io_di,
        output gnt0, m0_io_di, gnt1, m1_io_di,
        output flash_csb, flash_clk, flash_io_oe, flash_io_do,
        output busy, abort_cnt
    );

    modport master (
        output req0, m0_csb, m0_clk, m0_io_oe, m0_io_do,
        output req1, m1_csb, m1_clk, m1_io_oe, m1_io_do,
        output flash_io_di,
        input  gnt0, m0_io_di, gnt1, m1_io_di,
        input  flash_csb, flash_clk, flash_io_oe, flash_io_do,
        input  busy, abort_cnt
    );
endinterface

// File: rtl/flash_bus_arbiter.sv
// Two-master SPI flash arbiter: one owner at a time, a fixed idle guard between
// ownerships, round-robin on ties and a saturating count of aborted ownerships.
module flash_bus_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input logic                 clk,
    input logic                 nrst,
    flash_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

    state_t           state;
    logic             last_gnt;   // 1: master 1 was granted last
    logic             ready;      // blocks a grant on the first edge after reset
    logic [3:0]       guard_cnt;
    logic [CNT_W-1:0] abort_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            ready     <= 1'b0;
            guard_cnt <= 4'd0;
            abort_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (ready && bus.req0 && (!bus.req1 || last_gnt)) begin
                        state    <= OWN0;
                        gnt0_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        last_gnt <= 1'b0;
                    end else if (ready && bus.req1) begin
                        state    <= OWN1;
                        gnt1_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        last_gnt <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!bus.req0) begin
                        state     <= GUARD;
                        gnt0_q    <= 1'b0;
                        guard_cnt <= 4'(GUARD_CYCLES - 1);
                        if (!bus.m0_csb) abort_q <= sat_inc(abort_q);
                    end
                end
                OWN1: begin
                    if (!bus.req1) begin
                        state     <= GUARD;
                        gnt1_q    <= 1'b0;
                        guard_cnt <= 4'(GUARD_CYCLES - 1);
                        if (!bus.m1_csb) abort_q <= sat_inc(abort_q);
                    end
                end
                GUARD: begin
                    if (guard_cnt == 4'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pin routing follows the registered state only, so the non-owner never reaches the flash.
    always_comb begin
        bus.flash_csb   = 1'b1;
        bus.flash_clk   = 1'b0;
        bus.flash_io_oe = 4'h0;
        bus.flash_io_do = 4'h0;
        bus.m0_io_di    = 4'h0;
        bus.m1_io_di    = 4'h0;
        if (state == OWN0) begin
            bus.flash_csb   = bus.m0_csb;
            bus.flash_clk   = bus.m0_clk;
            bus.flash_io_oe = bus.m0_io_oe;
            bus.flash_io_do = bus.m0_io_do;
            bus.m0_io_di    = bus.flash_io_di;
        end else if (state == OWN1) begin
            bus.flash_csb   = bus.m1_csb;
            bus.flash_clk   = bus.m1_clk;
            bus.flash_io_oe = bus.m1_io_oe;
            bus.flash_io_do = bus.m1_io_do;
            bus.m1_io_di    = bus.flash_io_di;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = busy_q;
    assign bus.abort_cnt = abort_q;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: tie-breaking, pass-through, release,
// abort counting with saturation, non-preemption and asynchronous reset.
module tb_flash_bus_arbiter;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;

    flash_bus_arbiter_if #(.CNT_W(8)) bus ();

    flash_bus_arbiter #(.GUARD_CYCLES(4), .CNT_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_csb"}, 32'(bus.flash_csb), 32'h1);
        chk({tag, "_clk"}, 32'(bus.flash_clk), 32'h0);
        chk({tag, "_oe"},  32'(bus.flash_io_oe), 32'h0);
        chk({tag, "_do"},  32'(bus.flash_io_do), 32'h0);
        chk({tag, "_di0"}, 32'(bus.m0_io_di), 32'h0);
        chk({tag, "_di1"}, 32'(bus.m1_io_di), 32'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nrst  = 1'b0;
        bus.req0 = 1'b0; bus.m0_csb = 1'b1; bus.m0_clk = 1'b0; bus.m0_io_oe = 4'h0; bus.m0_io_do = 4'h0;
        bus.req1 = 1'b0; bus.m1_csb = 1'b1; bus.m1_clk = 1'b0; bus.m1_io_oe = 4'h0; bus.m1_io_do = 4'h0;
        bus.flash_io_di = 4'h5;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt0", 32'(bus.gnt0), 32'h0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_abort", 32'(bus.abort_cnt), 32'h0);
        chk_idle_pins("rst");

        // Tie right after reset: no grant on first edge, master 0 on second
        nrst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        chk("first_edge_gnt0", 32'(bus.gnt0), 32'h0);
        chk("first_edge_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("tie1_gnt0", 32'(bus.gnt0), 32'h1);
        chk("tie1_gnt1", 32'(bus.gnt1), 32'h0);
        chk("tie1_busy", 32'(bus.busy), 32'h1);

        // Master 0 drives the flash combinationally; master 1 pins are ignored
        bus.m0_csb = 1'b0; bus.m0_clk = 1'b1; bus.m0_io_oe = 4'hF; bus.m0_io_do = 4'hA;
        bus.m1_csb = 1'b0; bus.m1_clk = 1'b1; bus.m1_io_oe = 4'h3; bus.m1_io_do = 4'h6;
        #1;
        chk("own0_csb", 32'(bus.flash_csb), 32'h0);
        chk("own0_clk", 32'(bus.flash_clk), 32'h1);
        chk("own0_oe",  32'(bus.flash_io_oe), 32'hF);
        chk("own0_do",  32'(bus.flash_io_do), 32'hA);
        chk("own0_di0", 32'(bus.m0_io_di), 32'h5);
        chk("own0_di1", 32'(bus.m1_io_di), 32'h0);

        // Master 1 keeps requesting and toggling for 100 cycles without preempting
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.m1_clk = ~bus.m1_clk;
            bus.m1_io_do = 4'(i);
            bus.flash_io_di = 4'(i + 3);
            #1;
            chk("nopre_gnt1", 32'(bus.gnt1), 32'h0);
            chk("nopre_gnt0", 32'(bus.gnt0), 32'h1);
            chk("nopre_di1", 32'(bus.m1_io_di), 32'h0);
            chk("nopre_do", 32'(bus.flash_io_do), 32'hA);
            chk("nopre_clk", 32'(bus.flash_clk), 32'h1);
        end
        bus.flash_io_di = 4'h5;

        // Normal release by master 0: four GUARD cycles, then IDLE
        @(negedge clk);
        bus.m0_csb = 1'b1; bus.m0_clk = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        bus.req0 = 1'b1;  // ignored during GUARD
        for (int g = 0; g < 4; g++) begin
            chk("guard_busy", 32'(bus.busy), 32'h1);
            chk("guard_gnt0", 32'(bus.gnt0), 32'h0);
            chk("guard_gnt1", 32'(bus.gnt1), 32'h0);
            chk_idle_pins("guard");
            @(negedge clk);
        end
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("idle_gnt0", 32'(bus.gnt0), 32'h0);
        chk("idle_gnt1", 32'(bus.gnt1), 32'h0);
        chk("release_abort", 32'(bus.abort_cnt), 32'h0);

        // Second tie goes to master 1
        @(negedge clk);
        chk("tie2_gnt1", 32'(bus.gnt1), 32'h1);
        chk("tie2_gnt0", 32'(bus.gnt0), 32'h0);
        bus.req0 = 1'b0;
        bus.m1_csb = 1'b0; bus.m1_io_do = 4'hC; bus.flash_io_di = 4'h9;
        #1;
        chk("own1_csb", 32'(bus.flash_csb), 32'h0);
        chk("own1_do", 32'(bus.flash_io_do), 32'hC);
        chk("own1_di1", 32'(bus.m1_io_di), 32'h9);
        chk("own1_di0", 32'(bus.m0_io_di), 32'h0);

        // Master 1 aborts with csb still low
        @(negedge clk);
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("abort_csb", 32'(bus.flash_csb), 32'h1);
        chk("abort_gnt1", 32'(bus.gnt1), 32'h0);
        chk("abort_cnt1", 32'(bus.abort_cnt), 32'h1);
        repeat (4) @(negedge clk);
        chk("abort_idle", 32'(bus.busy), 32'h0);

        // Further aborts up to 2^8+3 in total: count saturates
        for (int a = 0; a < 258; a++) begin
            bus.req1 = 1'b1;
            @(negedge clk);
            bus.req1 = 1'b0;
            @(negedge clk);
            if (a == 0) chk("abort_cnt2", 32'(bus.abort_cnt), 32'h2);
            if (a == 253) chk("abort_cnt255", 32'(bus.abort_cnt), 32'hFF);
            repeat (4) @(negedge clk);
        end
        chk("abort_sat", 32'(bus.abort_cnt), 32'hFF);

        // Asynchronous reset in the middle of an OWN1 transfer
        bus.req1 = 1'b1;
        @(negedge clk);
        chk("own1b_gnt1", 32'(bus.gnt1), 32'h1);
        chk("own1b_csb", 32'(bus.flash_csb), 32'h0);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_csb", 32'(bus.flash_csb), 32'h1);
        chk("arst_gnt1", 32'(bus.gnt1), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_abort", 32'(bus.abort_cnt), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("post_rst_abort", 32'(bus.abort_cnt), 32'h0);
        chk("post_rst_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
